// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the pipeline run-state enum.
// The pipeline registers import this package as well.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    // A status that must stop the machine once it reaches write-back.
    function automatic logic is_exc(input logic [3:0] stat);
        return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        if (&v)
            return v;
        return v + W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (inc)
            q <= sat_inc(q);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, run-state sequencing
// (INIT flush, RUN, STOPPED) and saturating performance counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic [3:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

    state_t         state, state_nx;
    logic [ICW-1:0] init_cnt, init_cnt_nx;
    logic [3:0]     cpu_stat_nx;

    logic lu, mp, rt, ex_m, ex_w, run;

    // Hazard detection
    assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mp   = (E_icode == I_JXX) && !e_cnd;
    assign rt   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign ex_m = is_exc(m_stat);
    assign ex_w = is_exc(W_stat);
    assign run  = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            cpu_stat <= S_AOK;
        end else begin
            state    <= state_nx;
            init_cnt <= init_cnt_nx;
            cpu_stat <= cpu_stat_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        init_cnt_nx = init_cnt;
        cpu_stat_nx = cpu_stat;
        F_stall     = 1'b0;
        D_stall     = 1'b0;
        D_bubble    = 1'b0;
        E_bubble    = 1'b0;
        M_bubble    = 1'b0;
        W_stall     = 1'b0;
        unique case (state)
            ST_INIT: begin
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                if (init_cnt == INIT_LAST)
                    state_nx = ST_RUN;
                else
                    init_cnt_nx = init_cnt + ICW'(1);
            end
            ST_RUN: begin
                F_stall  = lu | rt;
                D_stall  = lu;
                // A load-use stall of D wins over the RET bubble.
                D_bubble = mp | (rt & ~lu);
                E_bubble = mp | lu;
                M_bubble = ex_m | ex_w;
                W_stall  = ex_w;
                if (ex_w) begin
                    state_nx    = ST_STOPPED;
                    cpu_stat_nx = W_stat;
                end
            end
            ST_STOPPED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    assign halted = (state == ST_STOPPED);

    // Performance counters advance only while running
    logic inc_cycle, inc_retire, inc_lu, inc_mp;

    assign inc_cycle  = run;
    assign inc_retire = run && (W_stat == S_AOK) && (W_icode != I_NOP) && !W_stall;
    assign inc_lu     = run && lu;
    assign inc_mp     = run && mp;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_cycle),
        .q   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_retire),
        .q   (retire_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_lu),
        .q   (lu_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mp_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_mp),
        .q   (mp_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 32-bit instance for function checks and a
// 4-bit-counter instance sharing the same stimulus for saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_icode, W_stat;
    logic        e_cnd;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
    logic [3:0]  cpu_stat;
    logic [31:0] cycle_cnt, retire_cnt, lu_cnt, mp_cnt;

    logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_halted;
    logic [3:0]  s_cpu_stat;
    logic [3:0]  s_cycle_cnt, s_retire_cnt, s_lu_cnt, s_mp_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.INIT_CYCLES(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .cpu_stat(cpu_stat), .halted(halted),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
    );

    pipe_ctrl #(.INIT_CYCLES(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble),
        .E_bubble(s_E_bubble), .M_bubble(s_M_bubble), .W_stall(s_W_stall),
        .cpu_stat(s_cpu_stat), .halted(s_halted),
        .cycle_cnt(s_cycle_cnt), .retire_cnt(s_retire_cnt), .lu_cnt(s_lu_cnt), .mp_cnt(s_mp_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA  = 4'hF; d_srcB  = 4'hF; E_dstM  = 4'hF;
        e_cnd   = 1'b0; m_stat  = 4'h1; W_stat  = 4'h1;
    endtask

    function automatic logic [5:0] ctl();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
    endfunction

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (cpu_stat !== 4'h1 || cycle_cnt !== 32'd0 || retire_cnt !== 32'd0 ||
            lu_cnt !== 32'd0 || mp_cnt !== 32'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: stat=%h cyc=%0d ret=%0d lu=%0d mp=%0d halted=%b want stat=1 all 0",
                     cpu_stat, cycle_cnt, retire_cnt, lu_cnt, mp_cnt, halted);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl() !== 6'b001110) begin
                failures++;
                $display("FAIL init_flush[%0d]: ctl=%b want 001110", i, ctl());
            end
            step();
        end
        checks++;
        if (ctl() !== 6'b000000 || cycle_cnt !== 32'd0) begin
            failures++;
            $display("FAIL run_entry: ctl=%b cyc=%0d want 000000 cyc=0", ctl(), cycle_cnt);
        end
        step();
        checks++;
        if (cycle_cnt !== 32'd1) begin
            failures++;
            $display("FAIL first_run_cycle: cyc=%0d want 1", cycle_cnt);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] lu0;
        set_idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        #1;
        lu0 = lu_cnt;
        checks++;
        if (ctl() !== 6'b110100) begin
            failures++;
            $display("FAIL load_use_ctl: ctl=%b want 110100", ctl());
        end
        step();
        checks++;
        if (lu_cnt !== lu0 + 32'd1) begin
            failures++;
            $display("FAIL load_use_cnt: lu=%0d want %0d", lu_cnt, lu0 + 32'd1);
        end
        E_dstM = 4'hF;
        #1;
        checks++;
        if (ctl() !== 6'b000000) begin
            failures++;
            $display("FAIL load_use_rnone: ctl=%b want 000000", ctl());
        end
        step();
        checks++;
        if (lu_cnt !== lu0 + 32'd1) begin
            failures++;
            $display("FAIL load_use_rnone_cnt: lu=%0d want %0d", lu_cnt, lu0 + 32'd1);
        end
    endtask

    task automatic test_mispredict();
        logic [31:0] mp0;
        set_idle();
        E_icode = 4'h7; e_cnd = 1'b0;
        #1;
        mp0 = mp_cnt;
        checks++;
        if (ctl() !== 6'b001100) begin
            failures++;
            $display("FAIL mispredict_ctl: ctl=%b want 001100", ctl());
        end
        step();
        checks++;
        if (mp_cnt !== mp0 + 32'd1) begin
            failures++;
            $display("FAIL mispredict_cnt: mp=%0d want %0d", mp_cnt, mp0 + 32'd1);
        end
        e_cnd = 1'b1;
        #1;
        checks++;
        if (ctl() !== 6'b000000) begin
            failures++;
            $display("FAIL taken_jump_ctl: ctl=%b want 000000", ctl());
        end
        step();
        checks++;
        if (mp_cnt !== mp0 + 32'd1) begin
            failures++;
            $display("FAIL taken_jump_cnt: mp=%0d want %0d", mp_cnt, mp0 + 32'd1);
        end
    endtask

    task automatic test_ret_lu();
        set_idle();
        M_icode = 4'h9;
        #1;
        checks++;
        if (ctl() !== 6'b101000) begin
            failures++;
            $display("FAIL ret_ctl: ctl=%b want 101000", ctl());
        end
        E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4;
        #1;
        checks++;
        if (ctl() !== 6'b110100) begin
            failures++;
            $display("FAIL ret_lu_ctl: ctl=%b want 110100", ctl());
        end
        step();
        set_idle();
        D_icode = 4'h9;
        #1;
        checks++;
        if (ctl() !== 6'b101000) begin
            failures++;
            $display("FAIL ret_in_d_ctl: ctl=%b want 101000", ctl());
        end
        step();
    endtask

    task automatic test_retire();
        logic [31:0] r0;
        set_idle();
        W_icode = 4'h6;
        #1;
        r0 = retire_cnt;
        step();
        step();
        checks++;
        if (retire_cnt !== r0 + 32'd2) begin
            failures++;
            $display("FAIL retire_count: ret=%0d want %0d", retire_cnt, r0 + 32'd2);
        end
        W_icode = 4'h1;
        step();
        checks++;
        if (retire_cnt !== r0 + 32'd2) begin
            failures++;
            $display("FAIL retire_nop: ret=%0d want %0d", retire_cnt, r0 + 32'd2);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] c0;
        set_idle();
        #1;
        c0 = cycle_cnt;
        for (int i = 0; i < 20; i++)
            step();
        checks++;
        if (s_cycle_cnt !== 4'd15) begin
            failures++;
            $display("FAIL cycle_saturate: cyc=%0d want 15", s_cycle_cnt);
        end
        checks++;
        if (cycle_cnt !== c0 + 32'd20) begin
            failures++;
            $display("FAIL cycle_wide: cyc=%0d want %0d", cycle_cnt, c0 + 32'd20);
        end
    endtask

    task automatic test_halt();
        logic [31:0] r0, c1, l1;
        set_idle();
        m_stat = 4'h2;
        #1;
        checks++;
        if (ctl() !== 6'b000010 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_in_m: ctl=%b halted=%b want 000010 0", ctl(), halted);
        end
        step();
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_in_m_run: halted=%b want 0", halted);
        end
        m_stat = 4'h1; W_stat = 4'h2; W_icode = 4'h0;
        #1;
        r0 = retire_cnt;
        checks++;
        if (ctl() !== 6'b000011) begin
            failures++;
            $display("FAIL halt_in_w: ctl=%b want 000011", ctl());
        end
        step();
        c1 = cycle_cnt;
        l1 = lu_cnt;
        checks++;
        if (halted !== 1'b1 || cpu_stat !== 4'h2 || retire_cnt !== r0) begin
            failures++;
            $display("FAIL stopped: halted=%b stat=%h ret=%0d want 1 2 %0d", halted, cpu_stat, retire_cnt, r0);
        end
        set_idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; W_icode = 4'h6;
        #1;
        checks++;
        if (ctl() !== 6'b110111) begin
            failures++;
            $display("FAIL stopped_ctl: ctl=%b want 110111", ctl());
        end
        step();
        step();
        step();
        checks++;
        if (cycle_cnt !== c1 || lu_cnt !== l1 || retire_cnt !== r0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL stopped_frozen: cyc=%0d lu=%0d ret=%0d halted=%b want %0d %0d %0d 1",
                     cycle_cnt, lu_cnt, retire_cnt, halted, c1, l1, r0);
        end
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (halted !== 1'b0 || cpu_stat !== 4'h1 || cycle_cnt !== 32'd0 || retire_cnt !== 32'd0 ||
            lu_cnt !== 32'd0 || mp_cnt !== 32'd0 || ctl() !== 6'b001110) begin
            failures++;
            $display("FAIL reset_from_stop: halted=%b stat=%h cyc=%0d ret=%0d lu=%0d mp=%0d ctl=%b",
                     halted, cpu_stat, cycle_cnt, retire_cnt, lu_cnt, mp_cnt, ctl());
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_mispredict();
        test_ret_lu();
        test_retire();
        test_saturation();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the Y86-64 five-stage pipe. It generates the stall/bubble controls for the F, D, E, M and W pipeline registers from hazard conditions. It sequences processor run state (INIT flush, RUN, STOPPED) and keeps performance counters. It sits beside the pipeline registers and drives their stall/bubble inputs, including M_bubble of the M register.

Parameters:
INIT_CYCLES, 4, cycles spent in INIT flushing D/E/M after reset (>=1)
CNT_W, 32, width of every performance counter

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
D_icode  in  4  icode in D register
d_srcA  in  4  decode srcA (4'hF = none)
d_srcB  in  4  decode srcB (4'hF = none)
E_icode  in  4  icode in E register
E_dstM  in  4  E-stage dstM (4'hF = none)
e_cnd  in  1  execute condition outcome
M_icode  in  4  icode in M register
m_stat  in  4  memory-stage status after dmem check
W_icode  in  4  icode in W register
W_stat  in  4  W register status
F_stall  out  1  hold F register
D_stall  out  1  hold D register
D_bubble  out  1  load NOP into D
E_bubble  out  1  load NOP into E
M_bubble  out  1  load NOP (icode 1) into M
W_stall  out  1  hold W register
cpu_stat  out  4  latched processor status
halted  out  1  state==STOPPED
cycle_cnt  out  CNT_W  cycles spent in RUN
retire_cnt  out  CNT_W  instructions retired
lu_cnt  out  CNT_W  load-use stall events
mp_cnt  out  CNT_W  mispredict events

Behaviour:
- Encodings: HALT 0, NOP 1, JXX 7, RET 9, MRMOVQ 5, POPQ B. Stat AOK 1, HLT 2, ADR 3, INS 4. RNONE F.
- Reset, sync and active-high, with priority over everything: state<=INIT, init counter<=0, cpu_stat<=AOK, all counters<=0.
- Reset asserted mid-operation behaves identically, regardless of state.
- Hazard terms (combinational):
  - lu = (E_icode==MRMOVQ | E_icode==POPQ) & E_dstM!=RNONE & (E_dstM==d_srcA | E_dstM==d_srcB)
  - mp = E_icode==JXX & !e_cnd
  - rt = RET in any of D_icode, E_icode, M_icode
  - exM = m_stat in {ADR,INS,HLT}
  - exW = W_stat in {ADR,INS,HLT}
- Outputs are a combinational function of state and inputs; no extra latency.
- INIT state:
  - D_bubble=E_bubble=M_bubble=1; F_stall=D_stall=W_stall=0.
  - After INIT_CYCLES cycles in INIT, the next state is RUN.
- RUN state:
  - F_stall = lu | rt
  - D_stall = lu
  - D_bubble = mp | (rt & !lu)
  - E_bubble = mp | lu
  - M_bubble = exM | exW
  - W_stall = exW
  - lu and mp are mutually exclusive by construction.
  - lu & rt gives D_stall=1, D_bubble=0, E_bubble=1.
- RUN -> STOPPED: on the edge where exW=1. cpu_stat<=W_stat on that edge. The same cycle already shows W_stall=1.
- STOPPED state:
  - F_stall=D_stall=W_stall=1; E_bubble=M_bubble=1; D_bubble=0.
  - Left only by reset. halted=1.
- Counters update only in RUN, evaluated per edge:
  - cycle_cnt +1 every RUN cycle.
  - retire_cnt +1 when W_stat==AOK & W_icode!=NOP & !W_stall.
  - lu_cnt +1 when lu.
  - mp_cnt +1 when mp.
- All counters saturate at 2^CNT_W-1; they do not wrap.
- INIT and STOPPED freeze all counters.

Decomposition:
- Shared package y86_pkg holds the icode constants, stat constants, RNONE and the state enum {INIT, RUN, STOPPED}; the pipeline registers reuse it.
- One natural sub-module: sat_counter (parameter W; ports clk, rst, inc, q), instantiated four times.
- Hazard terms and the FSM stay inline.

Test Plan:
- Reset, INIT_CYCLES=4: hold rst 2 cycles, release -> D/E/M_bubble=1 for exactly 4 cycles, then RUN with all controls 0 under NOP inputs; cycle_cnt=1 one edge after entering RUN.
- Load-use: E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; lu_cnt increments by 1. Repeat with E_dstM=F -> all 0.
- Mispredict: E_icode=7, e_cnd=0 -> D_bubble=E_bubble=1, F_stall=0, mp_cnt+1. With e_cnd=1 -> no bubble.
- RET with load-use: M_icode=9 alone -> F_stall=1, D_bubble=1. Then add lu (E_icode=B, E_dstM=4, d_srcA=4) -> D_stall=1, D_bubble=0.
- Halt: m_stat=2 -> M_bubble=1, still RUN. Next cycle W_stat=2 -> W_stall=1; after the edge halted=1, cpu_stat=2, counters frozen. Assert rst -> state INIT, cpu_stat=1, counters 0.
- Saturation, CNT_W=4: run 20 RUN cycles -> cycle_cnt stays 15. retire_cnt does not count W_icode=1 or a stalled W.
